writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

- Write-side master for the 64-bit integer `register_file`: merges results from the single-cycle ALU and the long-latency load/store unit (LSU) into that block's single write port (`we`/`wr_addr`/`wr_data`).
- Provides at most one register write per clock, buffers LSU results in a 2-entry FIFO, and suppresses writes to x0.
- Exports a pending-write mask that decode uses to stall reads of registers whose values are still in flight.

## Interface
- `XLEN`, 64: data width; must match `register_file`.
- `STARVE_LIMIT`, 4: consecutive cycles a waiting LSU result may lose to the ALU before it is forced through; range 1–15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result consumed this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in XLEN: ALU result.
- `lsu_valid` in 1: LSU result offered.
- `lsu_ready` out 1: LSU result accepted into the FIFO this cycle.
- `lsu_rd` in 5: LSU destination register.
- `lsu_data` in XLEN: LSU result.
- `we` out 1: register-file write enable.
- `wr_addr` out 5: register-file write address.
- `wr_data` out XLEN: register-file write data.
- `pending` out 32: bit i set while a write to xi is buffered or on the write port; bit 0 always 0.

## Operation
- **Transfers.** A transfer occurs when valid && ready on the rising edge. Producers hold rd/data stable while valid && !ready.
- **LSU FIFO.** 2 entries, registered.
  - `lsu_ready = !full`. This is combinational from FIFO state only and does not depend on `lsu_valid`.
  - No push when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop with 1 entry present: count stays at 1 and order is preserved.
- **Arbitration.** Evaluated each cycle; exactly one grant or none.
  - LSU head is granted if the FIFO is non-empty and either `alu_valid == 0` or `starve_cnt == STARVE_LIMIT`.
  - Otherwise the ALU is granted if `alu_valid`.
  - `alu_ready` is the ALU grant. It is combinational from `alu_valid`, FIFO state and `starve_cnt`.
- **Starvation counter.** `starve_cnt`, 4 bits.
  - Increments when the ALU is granted while the FIFO is non-empty.
  - Clears when the LSU is granted or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- **Output register.** The granted entry loads `wr_addr`/`wr_data` on the next edge.
  - `we` = 1 if a grant occurred and rd ≠ 0; otherwise 0.
  - An x0 result is still consumed (ready asserted, FIFO popped) but produces `we = 0`.
  - With no grant: `we = 0`, and `wr_addr`/`wr_data` hold their previous values.
- **Pending mask.** `pending[i]` = OR over valid FIFO entries with rd == i, OR (`we` && `wr_addr == i`), for i ≠ 0. Combinational from registers.
- **Reset.**
  - `we = 0`, `wr_addr = 0`, `wr_data = 0`, FIFO empty, `starve_cnt = 0`, `pending = 0`.
  - `alu_ready = 0` and `lsu_ready = 1` during the first cycle after reset.
  - Reset mid-operation discards buffered LSU results; results arriving on the reset edge are not accepted.

## Timing
- **ALU:** accepted at edge N; `we` asserted in cycle N..N+1 (1-cycle latency); register-file write lands at edge N+1.
- **LSU:** pushed at edge N; earliest grant in cycle N..N+1; `we` in cycle N+1..N+2 (2-cycle minimum latency).
- **Throughput:** 1 write per cycle sustained. The LSU backpressures only when 2 results are buffered.
- **Starvation bound:** worst-case LSU wait under continuous ALU traffic is STARVE_LIMIT cycles before grant.
- **Write order:** same-producer writes retire in acceptance order. Cross-producer order follows the grant order and must be made safe by decode via `pending`.

## Configuration
- **`WB_STARVE_GUARD_EN` defined:** the starvation counter and forced LSU grant are present, as described above.
- **`WB_STARVE_GUARD_EN` undefined:**
  - Strict ALU priority; the LSU is granted only when `alu_valid = 0`.
  - `starve_cnt` is removed and `STARVE_LIMIT` is ignored.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then release → `we = 0`, `wr_addr = 0`, `wr_data = 0`, `pending = 0`, `lsu_ready = 1`, `alu_ready = 0`.
- **ALU only:** `alu_valid` with rd = 5, data = 0xDEAD_BEEF accepted at edge N → `we = 1`, `wr_addr = 5`, `wr_data = 0xDEADBEEF` in the following cycle; `pending[5] = 1` for exactly that cycle.
- **x0:**
  - ALU rd = 0 → `alu_ready = 1`, `we` stays 0.
  - LSU rd = 0 → FIFO drains, `we` stays 0, `pending = 0` throughout.
- **FIFO full:**
  - Hold `alu_valid` high with the guard disabled; push LSU rd = 7, then rd = 8 → `lsu_ready = 0` on the third offer.
  - Drop `alu_valid` → writes x7 then x8 on consecutive cycles; `lsu_ready` returns to 1 after the first pop.
- **Starvation (guard on, STARVE_LIMIT = 4):** continuous ALU traffic plus one LSU result rd = 9 → 4 ALU writes, then x9 written, with `alu_ready = 0` on the grant cycle, then ALU writes resume.
- **Reset mid-flight:** 2 LSU entries buffered, assert `rst` for 1 cycle → FIFO empty, no write to those rd, `pending = 0` after release.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Write-port arbiter merging ALU and buffered LSU results into the register file.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module writeback_arbiter #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            we,
   output logic [4:0]      wr_addr,
   output logic [XLEN-1:0] wr_data,
   output logic [31:0]     pending
);

   localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

   logic [4:0]      fifo_rd_q   [2];
   logic [4:0]      fifo_rd_d   [2];
   logic [XLEN-1:0] fifo_data_q [2];
   logic [XLEN-1:0] fifo_data_d [2];
   logic            rd_ptr_q, rd_ptr_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic [1:0]      count_q, count_d;
   logic            we_q, we_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;

   logic full, empty, push, pop;
   logic lsu_grant, alu_grant;
   logic [4:0] sel_rd;
   logic [XLEN-1:0] sel_data;

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign push  = lsu_valid && !full;
   assign pop   = lsu_grant;

`ifdef WB_STARVE_GUARD_EN
   logic [3:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      lsu_grant    = !empty && (!alu_valid || (starve_cnt_q == StarveLim));
      alu_grant    = alu_valid && !lsu_grant;
      starve_cnt_d = starve_cnt_q;
      if (empty || lsu_grant) begin
         starve_cnt_d = 4'd0;
      end else if (alu_grant && (starve_cnt_q != StarveLim)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   logic unused_starve_lim;
   assign unused_starve_lim = ^StarveLim;

   always_comb begin
      lsu_grant = !empty && !alu_valid;
      alu_grant = alu_valid;
   end
`endif

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      if (push) begin
         fifo_rd_d[wr_ptr_q]   = lsu_rd;
         fifo_data_d[wr_ptr_q] = lsu_data;
      end
      wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!push && pop) begin
         count_d = count_q - 2'd1;
      end
   end

   always_comb begin
      sel_rd    = lsu_grant ? fifo_rd_q[rd_ptr_q] : alu_rd;
      sel_data  = lsu_grant ? fifo_data_q[rd_ptr_q] : alu_data;
      we_d      = (lsu_grant || alu_grant) && (sel_rd != 5'd0);
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (lsu_grant || alu_grant) begin
         wr_addr_d = sel_rd;
         wr_data_d = sel_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         we_q      <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_data_q <= '0;
      end else begin
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         we_q      <= we_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Entry storage needs no reset; validity comes from count_q.
   always_ff @(posedge clk) begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
   end

   always_comb begin
      pending = '0;
      for (int k = 0; k < 2; k++) begin
         if ((count_q == 2'd2) || ((count_q == 2'd1) && (rd_ptr_q == 1'(k)))) begin
            pending[fifo_rd_q[k]] = 1'b1;
         end
      end
      if (we_q) begin
         pending[wr_addr_q] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   assign lsu_ready = !full;
   assign alu_ready = alu_grant;
   assign we        = we_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected writes queued in grant order.
module tb_writeback_arbiter;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, alu_ready, lsu_valid, lsu_ready, we;
   logic [4:0]      alu_rd, lsu_rd, wr_addr;
   logic [XLEN-1:0] alu_data, lsu_data, wr_data;
   logic [31:0]     pending;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   writeback_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every asserted write must match the oldest expected write.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got x%0d data %0h expected no write", wr_addr,
                     wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(e.rd));
            check("wr_data", wr_data, e.data);
         end
      end
   end

   // Drive one cycle of inputs and check the combinational handshakes before the edge.
   task automatic cyc(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                      input logic ear, input logic elr, input string nm);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = ad;
      lsu_valid = lv;
      lsu_rd    = lrd;
      lsu_data  = ld;
      #2;
      check({nm, "_alu_ready"}, 64'(alu_ready), 64'(ear));
      check({nm, "_lsu_ready"}, 64'(lsu_ready), 64'(elr));
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
      wr_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string nm);
      cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_we", 64'(we), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_pending", 64'(pending), 64'd0);
      #1;
      check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
      check("rst_alu_ready", 64'(alu_ready), 64'd0);

      // ALU only
      expect_wr(5'd5, 64'hDEAD_BEEF);
      cyc(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, "alu5");
      check("alu5_pending", 64'(pending), 64'h20);
      idle("alu5_idle");
      check("alu5_pending_clr", 64'(pending), 64'd0);

      // x0 from ALU and from LSU
      cyc(1'b1, 5'd0, 64'h123, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, "alu_x0");
      check("alu_x0_we", 64'(we), 64'd0);
      cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55, 1'b0, 1'b1, "lsu_x0");
      check("lsu_x0_pend_a", 64'(pending), 64'd0);
      idle("lsu_x0_drain");
      check("lsu_x0_we", 64'(we), 64'd0);
      check("lsu_x0_pend_b", 64'(pending), 64'd0);
      idle("lsu_x0_empty");

      // FIFO full under ALU traffic, then drain
      expect_wr(5'd1, 64'h11);
      cyc(1'b1, 5'd1, 64'h11, 1'b1, 5'd7, 64'h70, 1'b1, 1'b1, "full_a");
      check("full_a_pend", 64'(pending), 64'h82);
      expect_wr(5'd2, 64'h22);
      cyc(1'b1, 5'd2, 64'h22, 1'b1, 5'd8, 64'h80, 1'b1, 1'b1, "full_b");
      check("full_b_pend", 64'(pending), 64'h184);
      expect_wr(5'd3, 64'h33);
      cyc(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h90, 1'b1, 1'b0, "full_c");
      expect_wr(5'd7, 64'h70);
      cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h90, 1'b0, 1'b0, "full_d");
      expect_wr(5'd8, 64'h80);
      cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h90, 1'b0, 1'b1, "full_e");
      check("full_e_pend", 64'(pending), 64'h300);
      expect_wr(5'd9, 64'h90);
      cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, "full_f");
      check("full_f_pend", 64'(pending), 64'h200);
      idle("full_idle");

      // Starvation: one LSU result under continuous ALU traffic
      expect_wr(5'd10, 64'hA0);
      cyc(1'b1, 5'd10, 64'hA0, 1'b1, 5'd9, 64'h99, 1'b1, 1'b1, "stv_0");
      check("stv_0_pend", 64'(pending), 64'h600);
      for (int i = 1; i <= 4; i++) begin
         expect_wr(5'(10 + i), 64'(160 + i));
         cyc(1'b1, 5'(10 + i), 64'(160 + i), 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, "stv_alu");
      end
`ifdef WB_STARVE_GUARD_EN
      expect_wr(5'd9, 64'h99);
      cyc(1'b1, 5'd15, 64'hF0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, "stv_force");
      expect_wr(5'd15, 64'hF0);
      cyc(1'b1, 5'd15, 64'hF0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, "stv_resume");
`else
      expect_wr(5'd15, 64'hF0);
      cyc(1'b1, 5'd15, 64'hF0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b1, "stv_prio");
      expect_wr(5'd9, 64'h99);
      idle("stv_drain");
`endif
      idle("stv_idle");
      check("stv_pend", 64'(pending), 64'd0);

      // Reset with two LSU results buffered
      expect_wr(5'd20, 64'h200);
      cyc(1'b1, 5'd20, 64'h200, 1'b1, 5'd21, 64'h210, 1'b1, 1'b1, "mrst_a");
      expect_wr(5'd22, 64'h220);
      cyc(1'b1, 5'd22, 64'h220, 1'b1, 5'd23, 64'h230, 1'b1, 1'b1, "mrst_b");
      check("mrst_pend_pre", 64'(pending), 64'hE0_0000);
      rst = 1'b1;
      alu_valid = 1'b0;
      lsu_valid = 1'b1;
      lsu_rd    = 5'd24;
      lsu_data  = 64'h240;
      @(posedge clk);
      #1;
      rst = 1'b0;
      lsu_valid = 1'b0;
      check("mrst_we", 64'(we), 64'd0);
      check("mrst_pend", 64'(pending), 64'd0);
      for (int i = 0; i < 3; i++) begin
         idle("mrst_idle");
         check("mrst_pend_idle", 64'(pending), 64'd0);
      end

      #20;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
